// File: rtl/sail_stdout_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sail_stdout_drain                                                        |
// | Streams newly appended characters of the cumulative Sail stdout string   |
// | out as bytes on a valid/ready interface through a small FIFO.            |
// | Optional: SAIL_STDOUT_DRAIN_CRLF_EN expands 0x0A into 0x0D 0x0A.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sail_stdout_drain #(
  parameter int DEPTH = 8,
  parameter int IDX_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  string            in_sail_stdout,
  output logic [7:0]       out_byte,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_count,
  output logic             out_resync,
  output logic             out_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [7:0] C_LF = 8'h0A;
  localparam logic [7:0] C_CR = 8'h0D;

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] out_count_q, out_count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             resync_q, resync_d;
  logic [7:0]       mem_q [DEPTH];

  logic [IDX_W-1:0] str_len;
  logic [7:0]       fetch_char;
  logic [7:0]       head;
  logic             head_is_lf;
  logic             handshake;
  logic             hold_lf;
  logic             push;
  logic             pop;
  logic             shrink;

  assign out_valid  = (cnt_q != '0);
  assign head       = mem_q[rd_ptr_q];
  assign head_is_lf = (head == C_LF);
  assign handshake  = out_valid && out_ready;
  assign out_count  = out_count_q;
  assign out_resync = resync_q;
  // Gated by rst so the sink sees an idle block for the whole reset window.
  assign out_busy   = !rst && (out_valid || (str_len != idx_q));

`ifdef SAIL_STDOUT_DRAIN_CRLF_EN
  localparam logic [0:0] ST_NORMAL     = 1'b0;
  localparam logic [0:0] ST_LF_PENDING = 1'b1;

  logic [0:0] state_q, state_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_NORMAL;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_NORMAL:     if (handshake && head_is_lf) state_d = ST_LF_PENDING;
      ST_LF_PENDING: if (handshake)               state_d = ST_NORMAL;
      default:                                    state_d = ST_NORMAL;
    endcase
  end

  // The CR half of a line ending is presented without consuming the LF.
  always_comb begin
    hold_lf  = (state_q == ST_NORMAL) && head_is_lf;
    out_byte = 8'h00;
    if (out_valid) out_byte = hold_lf ? C_CR : head;
  end
`else
  always_comb begin
    hold_lf  = 1'b0;
    out_byte = out_valid ? head : 8'h00;
  end
`endif

  always_comb begin
    str_len    = IDX_W'(in_sail_stdout.len());
    fetch_char = in_sail_stdout[int'(idx_q)];
    pop        = handshake && !hold_lf;
    shrink     = (str_len < idx_q);
    push       = (str_len > idx_q) && ((cnt_q < C_DEPTH) || pop);

    idx_d       = idx_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    resync_d    = shrink;
    out_count_d = handshake ? out_count_q + IDX_W'(1) : out_count_q;

    // A replaced string restarts tracking at its new end; queued bytes still drain.
    if (shrink)    idx_d = str_len;
    else if (push) idx_d = idx_q + IDX_W'(1);

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      out_count_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      resync_q    <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      out_count_q <= out_count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      resync_q    <= resync_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fetch_char;
  end

endmodule
`default_nettype wire

// File: tb/tb_sail_stdout_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sail_stdout_drain                                                     |
// | Directed stimulus with a queue-based stream model for sail_stdout_drain. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_sail_stdout_drain;

  localparam int DEPTH = 8;
  localparam int IDX_W = 32;
`ifdef SAIL_STDOUT_DRAIN_CRLF_EN
  localparam int LF_EXTRA = 1;
`else
  localparam int LF_EXTRA = 0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  string            s = "";
  logic [7:0]       out_byte;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [IDX_W-1:0] out_count;
  logic             out_resync;
  logic             out_busy;

  int               n_cmp = 0;
  int               n_bad = 0;
  logic [7:0]       expq[$];
  logic [7:0]       got[$];
  logic [31:0]      hs_cnt = 0;
  logic             prev_stall = 1'b0;
  logic [7:0]       prev_byte = 8'h00;
  int               g0;

  sail_stdout_drain #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_sail_stdout (s),
    .out_byte       (out_byte),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_count      (out_count),
    .out_resync     (out_resync),
    .out_busy       (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected byte stream for a piece of text, with optional line-ending expansion.
  task automatic expect_str(input string t);
    for (int i = 0; i < t.len(); i++) begin
      logic [7:0] c;
      c = t[i];
`ifdef SAIL_STDOUT_DRAIN_CRLF_EN
      if (c == 8'h0A) expq.push_back(8'h0D);
`endif
      expq.push_back(c);
    end
  endtask

  task automatic append(input string t);
    expect_str(t);
    s = {s, t};
  endtask

  task automatic cycle_check();
    if (prev_stall) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_byte", {24'd0, out_byte}, {24'd0, prev_byte});
    end
    check("out_count", out_count, hs_cnt);
    if (expq.size() == 0) check("idle_valid", {31'd0, out_valid}, 32'd0);
    else                  check("busy_pending", {31'd0, out_busy}, 32'd1);
    if (out_valid && out_ready) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL stream_byte: got 0x%0h, expected no byte", out_byte);
      end else begin
        check("stream_byte", {24'd0, out_byte}, {24'd0, expq.pop_front()});
      end
      got.push_back(out_byte);
      hs_cnt++;
    end
    prev_stall = out_valid && !out_ready;
    prev_byte  = out_byte;
  endtask

  // Advance one cycle: model check at negedge, return at posedge + 1.
  task automatic tick();
    @(negedge clk);
    if (!rst) cycle_check();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((expq.size() != 0 || out_valid) && n < 64) begin
      tick();
      n++;
    end
    n_cmp++;
    if (expq.size() != 0 || out_valid) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d bytes left, expected 0", expq.size());
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    #2;
    check("rst_valid",  {31'd0, out_valid},  32'd0);
    check("rst_byte",   {24'd0, out_byte},   32'd0);
    check("rst_count",  out_count,           32'd0);
    check("rst_resync", {31'd0, out_resync}, 32'd0);
    check("rst_busy",   {31'd0, out_busy},   32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // "" -> "Hi" with the sink ready
    out_ready = 1'b1;
    append("Hi");
    tick();
    check("hi_valid", {31'd0, out_valid}, 32'd1);
    check("hi_byte0", {24'd0, out_byte}, 32'h48);
    tick();
    check("hi_byte1", {24'd0, out_byte}, 32'h69);
    tick();
    check("hi_count", out_count, 32'd2);
    check("hi_busy",  {31'd0, out_busy}, 32'd0);

    // Back-pressure fills the FIFO, then full-rate drain
    out_ready = 1'b0;
    append("0123456789");
    repeat (10) tick();
    check("full_byte", {24'd0, out_byte}, 32'h30);
    check("full_occ",  {28'd0, dut.cnt_q}, DEPTH);
    check("full_idx",  dut.idx_q, 32'd10);
    out_ready = 1'b1;
    g0 = got.size();
    repeat (10) tick();
    check("burst_len", got.size() - g0, 32'd10);
    for (int i = 0; i < 10; i++)
      check("burst_byte", {24'd0, got[g0 + i]}, 32'h30 + i);
    check("burst_count", out_count, 32'd12);

    // Line ending with a toggling sink
    g0 = got.size();
    append("ok\n");
    for (int i = 0; i < 12; i++) begin
      out_ready = (i % 2 == 1);
      tick();
    end
    drain();
    check("ok_count", out_count, 32'd15 + LF_EXTRA);
    check("ok_byte0", {24'd0, got[g0]},     32'h6F);
    check("ok_byte1", {24'd0, got[g0 + 1]}, 32'h6B);
`ifdef SAIL_STDOUT_DRAIN_CRLF_EN
    check("ok_cr",    {24'd0, got[g0 + 2]}, 32'h0D);
`endif
    check("ok_lf",    {24'd0, got[got.size() - 1]}, 32'h0A);

    // String replaced by a shorter one, then extended
    append("abcdef");
    drain();
    s = "xy";
    tick();
    check("resync_hi",  {31'd0, out_resync}, 32'd1);
    check("resync_idx", dut.idx_q, 32'd2);
    tick();
    check("resync_lo",    {31'd0, out_resync}, 32'd0);
    check("resync_valid", {31'd0, out_valid},  32'd0);
    check("resync_busy",  {31'd0, out_busy},   32'd0);
    append("z");
    drain();
    check("ext_byte",  {24'd0, got[got.size() - 1]}, 32'h7A);
    check("ext_count", out_count, 32'd22 + LF_EXTRA);

    // Asynchronous reset with three bytes queued
    out_ready = 1'b0;
    s = "";
    tick();
    append("abc");
    repeat (4) tick();
    check("pre_rst_occ", {28'd0, dut.cnt_q}, 32'd3);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, out_valid}, 32'd0);
    check("arst_byte",  {24'd0, out_byte},  32'd0);
    check("arst_count", out_count,          32'd0);
    check("arst_busy",  {31'd0, out_busy},  32'd0);
    expq.delete();
    hs_cnt     = 0;
    prev_stall = 1'b0;
    expect_str("abc");
    @(posedge clk);
    #1 rst = 1'b0;
    g0 = got.size();
    drain();
    check("reemit_len", got.size() - g0, 32'd3);
    check("reemit_a", {24'd0, got[g0]},     32'h61);
    check("reemit_b", {24'd0, got[g0 + 1]}, 32'h62);
    check("reemit_c", {24'd0, got[g0 + 2]}, 32'h63);
    check("reemit_count", out_count, 32'd3);

    // Full FIFO with simultaneous push and pop
    out_ready = 1'b0;
    g0 = got.size();
    append("ABCDEFGHIJKLMNOPQRST");
    repeat (10) tick();
    check("pp_full", {28'd0, dut.cnt_q}, DEPTH);
    out_ready = 1'b1;
    tick();
    check("pp_occ1", {28'd0, dut.cnt_q}, DEPTH);
    check("pp_idx",  dut.idx_q, 32'd12);
    tick();
    check("pp_occ2", {28'd0, dut.cnt_q}, DEPTH);
    for (int i = 0; i < 30; i++) begin
      out_ready = (i % 3 != 0);
      tick();
    end
    drain();
    check("pp_len",   got.size() - g0, 32'd20);
    for (int i = 0; i < 20; i++)
      check("pp_byte", {24'd0, got[g0 + i]}, 32'h41 + i);
    check("pp_count", out_count, 32'd23);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
